im_arbiter: RTL and testbench

Single-port instruction-memory arbiter placed between the fetch stage and the instruction memory. It shares the memory port between the fetch stage (read-only, single-beat) and the boot loader (read/write, locked bursts). It drives the memory's address, chip enable and write controls, and returns read data with a one-cycle valid strobe to the winning requester. Loader bursts are atomic; an optional starvation guard lets fetch interleave into long bursts.

---
 rtl/im_arbiter.sv | 120 ++++++++++++
 tb/tb_im_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/im_arbiter.sv
// Instruction-memory port arbiter: fetch (single-beat reads) vs boot loader (locked bursts).
// Optional starvation guard enabled by defining IM_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | port free; loader has priority, fetch granted otherwise
// LOAD  | loader burst in progress; port locked to the loader
module im_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_last,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] imaddr,
  output logic              imce,
  output logic              imwe,
  output logic [DATA_W-1:0] imwdata,
  input  logic [DATA_W-1:0] imrdata
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t state_q, state_d;
  logic   if_gnt_c, ld_gnt_c;
  logic   force_if;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("im_arbiter: STARVE_MAX out of range 1..255");
  end

`ifdef IM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;

  // Forced fetch slot only when fetch is actually waiting.
  assign force_if = (state_q == LOAD) && if_req && (starve_cnt == STARVE_LIM);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt || state_d == IDLE) begin
      starve_cnt <= '0;
    end else if (state_q == LOAD && if_req && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    if_gnt_c = 1'b0;
    ld_gnt_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_req) begin
          ld_gnt_c = 1'b1;
          if (!ld_last) state_d = LOAD;
        end else if (if_req) begin
          if_gnt_c = 1'b1;
        end
      end
      LOAD: begin
        if (force_if) begin
          if_gnt_c = 1'b1;
        end else if (ld_req) begin
          ld_gnt_c = 1'b1;
          if (ld_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational, so they are gated to stay quiet while reset is held.
  assign if_gnt = if_gnt_c & cpu_rst_n;
  assign ld_gnt = ld_gnt_c & cpu_rst_n;

  assign imce    = if_gnt | ld_gnt;
  assign imwe    = ld_gnt & ld_we;
  assign imaddr  = if_gnt ? if_addr : (ld_gnt ? ld_addr : '0);
  assign imwdata = imwe ? ld_wdata : '0;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
    end else begin
      if_rvalid <= if_req & if_gnt;
      ld_rvalid <= ld_req & ld_gnt & ~ld_we;
    end
  end

  assign if_rdata = imrdata;
  assign ld_rdata = imrdata;

endmodule

// File: tb/tb_im_arbiter.sv
// Scoreboard bench for im_arbiter: driver queues expected per-cycle outputs and read data,
// a negedge monitor pops and compares. Guard scenario runs when IM_ARB_STARVE_GUARD_EN is defined.
module tb_im_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          cpu_clk_50M;
  logic          cpu_rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ld_req, ld_we, ld_last, ld_gnt, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic [AW-1:0] imaddr;
  logic          imce, imwe;
  logic [DW-1:0] imwdata, imrdata;

  im_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(2)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_last(ld_last), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .imaddr(imaddr), .imce(imce), .imwe(imwe), .imwdata(imwdata), .imrdata(imrdata)
  );

  initial begin
    cpu_clk_50M = 1'b1;
    forever #10 cpu_clk_50M = ~cpu_clk_50M;
  end

  // Memory model: registered read, write on the edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
    imrdata = '0;
  end
  always @(posedge cpu_clk_50M) begin
    if (imce && !imwe) imrdata <= mem[imaddr];
    if (imce && imwe)  mem[imaddr] <= imwdata;
  end

  typedef struct {
    logic          ig, lg, ce, we, irv, lrv;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_vec  = 0;
  int            n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endfunction

  always @(negedge cpu_clk_50M) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("if_gnt",    32'(if_gnt),    32'(e.ig));
      chk("ld_gnt",    32'(ld_gnt),    32'(e.lg));
      chk("imce",      32'(imce),      32'(e.ce));
      chk("imwe",      32'(imwe),      32'(e.we));
      chk("imaddr",    32'(imaddr),    32'(e.a));
      chk("imwdata",   imwdata,        e.wd);
      chk("if_rvalid", 32'(if_rvalid), 32'(e.irv));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(e.lrv));
    end
    if (if_rvalid || ld_rvalid) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rdata_unexpected at %0t: got rvalid with no queued read", $time);
      end else begin
        chk("rdata", if_rvalid ? if_rdata : ld_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic rst, input logic ifr, input logic [AW-1:0] ia,
                     input logic ldr, input logic we, input logic [AW-1:0] la,
                     input logic [DW-1:0] wd, input logic last,
                     input logic e_ig, input logic e_lg, input logic e_irv, input logic e_lrv);
    exp_t e;
    cpu_rst_n = rst;
    if_req = ifr;  if_addr = ia;
    ld_req = ldr;  ld_we = we;  ld_addr = la;  ld_wdata = wd;  ld_last = last;
    e.ig  = e_ig;
    e.lg  = e_lg;
    e.ce  = e_ig | e_lg;
    e.we  = e_lg & we;
    e.a   = e_ig ? ia : (e_lg ? la : '0);
    e.wd  = (e_lg & we) ? wd : '0;
    e.irv = e_irv;
    e.lrv = e_lrv;
    exp_q.push_back(e);
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic idle(input logic irv, input logic lrv);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, irv, lrv);
  endtask

  task automatic rd(input logic [DW-1:0] d);
    rd_q.push_back(d);
  endtask

`ifdef IM_ARB_STARVE_GUARD_EN
  localparam logic GAP_IFR = 1'b0;
`else
  localparam logic GAP_IFR = 1'b1;
`endif

  initial begin
    // reset state, with requests present
    cyc(0, 1, 13'h010, 1, 0, 13'h020, 0, 0,  0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0);

    // single fetch read
    cyc(1, 1, 13'h010, 0, 0, 0, 0, 0,        1, 0, 0, 0);  rd(32'hA000_0010);
    idle(1, 0);

    // both request in IDLE; loader single-beat read wins
    cyc(1, 1, 13'h020, 1, 0, 13'h030, 0, 1,  0, 1, 0, 0);  rd(32'hA000_0030);
    cyc(1, 1, 13'h020, 0, 0, 0, 0, 0,        1, 0, 0, 1);  rd(32'hA000_0020);
    idle(1, 0);

`ifdef IM_ARB_STARVE_GUARD_EN
    // 6-beat write burst with fetch waiting; STARVE_MAX=2 forces fetch slots
    cyc(1, 1, 13'h050, 1, 1, 13'h200, 32'hB0, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h050, 1, 1, 13'h201, 32'hB1, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h050, 1, 1, 13'h202, 32'hB2, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h050, 1, 1, 13'h203, 32'hB3, 0,  1, 0, 0, 0);  rd(32'hA000_0050);
    cyc(1, 1, 13'h050, 1, 1, 13'h203, 32'hB3, 0,  0, 1, 1, 0);
    cyc(1, 1, 13'h050, 1, 1, 13'h204, 32'hB4, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h050, 1, 1, 13'h205, 32'hB5, 1,  1, 0, 0, 0);  rd(32'hA000_0050);
    cyc(1, 1, 13'h050, 1, 1, 13'h205, 32'hB5, 1,  0, 1, 1, 0);
    cyc(1, 1, 13'h050, 0, 0, 0, 0, 0,             1, 0, 0, 0);  rd(32'hA000_0050);
    // read back a burst word to prove all beats landed
    cyc(1, 0, 0, 1, 0, 13'h205, 0, 1,             0, 1, 1, 0);  rd(32'h0000_00B5);
    idle(0, 1);
`else
    // 4-beat write burst, fetch blocked for the whole burst
    cyc(1, 1, 13'h040, 1, 1, 13'h100, 32'hD0, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h040, 1, 1, 13'h101, 32'hD1, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h040, 1, 1, 13'h102, 32'hD2, 0,  0, 1, 0, 0);
    cyc(1, 1, 13'h040, 1, 1, 13'h103, 32'hD3, 1,  0, 1, 0, 0);
    cyc(1, 1, 13'h040, 0, 0, 0, 0, 0,             1, 0, 0, 0);  rd(32'hA000_0040);
    cyc(1, 0, 0, 1, 0, 13'h102, 0, 1,             0, 1, 1, 0);  rd(32'h0000_00D2);
    idle(0, 1);
`endif

    // reset during beat 2 of a burst
    cyc(1, 0, 0, 1, 1, 13'h300, 32'hE0, 0,        0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 13'h301, 32'hE1, 0,        0, 1, 0, 0);
    cyc(0, 1, 13'h060, 1, 1, 13'h302, 32'hE2, 0,  0, 0, 0, 0);
    cyc(1, 1, 13'h060, 0, 0, 0, 0, 0,             1, 0, 0, 0);  rd(32'hA000_0060);
    idle(1, 0);

    // burst with a 3-cycle loader gap: lock held, port idle
    cyc(1, 0, 0, 1, 0, 13'h110, 0, 0,                     0, 1, 0, 0);  rd(32'hA000_0110);
    cyc(1, 0, 0, 1, 0, 13'h111, 0, 0,                     0, 1, 0, 1);  rd(32'hA000_0111);
    cyc(1, GAP_IFR, 13'h070, 0, 0, 0, 0, 1,               0, 0, 0, 1);
    cyc(1, GAP_IFR, 13'h070, 0, 0, 0, 0, 0,               0, 0, 0, 0);
    cyc(1, GAP_IFR, 13'h070, 0, 0, 0, 0, 0,               0, 0, 0, 0);
    cyc(1, 1, 13'h070, 1, 1, 13'h112, 32'hCAFE_F00D, 1,   0, 1, 0, 0);
    cyc(1, 1, 13'h070, 0, 0, 0, 0, 0,                     1, 0, 0, 0);  rd(32'hA000_0070);
    idle(1, 0);
    idle(0, 0);

    @(negedge cpu_clk_50M);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_q_drained",  32'(rd_q.size()),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
